// File: rtl/seq_control_unit.sv
// seq_control_unit: multi-cycle instruction sequencer. Latches one instruction
// per fetch handshake, decodes it, and sequences commit through ALU and
// data-memory wait states, abandoning a wait after TIMEOUT cycles.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// FETCH    | instr_ready high, waiting for a valid instruction
// EXEC     | decode outputs live, branch condition registered, wait chosen
// WAIT_ALU | multi-cycle ALU op in flight, watching alu_done
// WAIT_MEM | data-memory request held, watching mem_ack
// COMMIT   | one-cycle write-back / PC / stack pulses
//
// Instruction layout (INSTR_W >= 11): [opcode:6][rd:2][rs:2][imm:rest].
module seq_control_unit #(
  parameter int INSTR_W = 16,
  parameter int NREG    = 3,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  input  logic [3:0]         flags,
  output logic [4:0]         opsel,
  output logic [1:0]         sel_srcA,
  output logic [1:0]         sel_srcB,
  output logic               alu_start,
  input  logic               alu_done,
  output logic               mem_req,
  output logic               mem_we,
  input  logic               mem_ack,
  output logic [1:0]         data_addr_sel,
  output logic [1:0]         mem_data_wr_sel,
  output logic               push,
  output logic               op_stack,
  output logic [NREG-1:0]    wr_reg,
  output logic               reg_from_mem,
  output logic               save_flags,
  output logic               branch,
  output logic               ret,
  output logic               load_pc,
  output logic               busy,
  output logic               timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Counter value seen during the TIMEOUT-th wait cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [5:0] OP_ADDRR = 6'h01, OP_ADDRI = 6'h02, OP_SUBRR = 6'h03,
                         OP_SUBRI = 6'h04, OP_ANDRR = 6'h05, OP_ORRR  = 6'h06,
                         OP_XORRR = 6'h07, OP_SHL   = 6'h08, OP_SHR   = 6'h09,
                         OP_MULRR = 6'h0A, OP_DIVRR = 6'h0B, OP_MODRR = 6'h0C,
                         OP_POWRR = 6'h0D, OP_RADRR = 6'h0E, OP_CMP   = 6'h0F,
                         OP_TST   = 6'h10, OP_INC   = 6'h11, OP_DEC   = 6'h12,
                         OP_MOV   = 6'h13, OP_LOAD  = 6'h14, OP_STORE = 6'h15,
                         OP_LOADB = 6'h16, OP_STOREB= 6'h17, OP_PUSH  = 6'h18,
                         OP_POP   = 6'h19, OP_JMP   = 6'h1A, OP_RET   = 6'h1B,
                         OP_BRE   = 6'h20, OP_BNE   = 6'h21, OP_BLT   = 6'h22,
                         OP_BGT   = 6'h23, OP_BLE   = 6'h24, OP_BGE   = 6'h25,
                         OP_BRC   = 6'h26, OP_BRO   = 6'h27, OP_BRA   = 6'h28;

  localparam logic [4:0] ALU_ADD = 5'd1,  ALU_SUB = 5'd2,  ALU_AND = 5'd3,
                         ALU_OR  = 5'd4,  ALU_XOR = 5'd5,  ALU_SHL = 5'd6,
                         ALU_SHR = 5'd7,  ALU_MUL = 5'd8,  ALU_DIV = 5'd9,
                         ALU_MOD = 5'd10, ALU_POW = 5'd11, ALU_RAD = 5'd12,
                         ALU_INC = 5'd13, ALU_DEC = 5'd14, ALU_MOV = 5'd15;

  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_WAIT_ALU, S_WAIT_MEM, S_COMMIT} state_t;

  state_t           state_q, state_d;
  logic [9:0]       instr_q, instr_d;
  logic             cond_q, cond_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             terr_q, terr_d;

  // The immediate field is consumed by the datapath straight from fetch.
  logic unused_imm;
  assign unused_imm = ^instr[INSTR_W-11:0];

  logic [5:0] opc;
  logic [1:0] rd, rs;
  logic zf, nf, cf, of;
  assign opc = instr_q[9:4];
  assign rd  = instr_q[3:2];
  assign rs  = instr_q[1:0];
  assign {zf, nf, cf, of} = flags;

  logic [NREG-1:0] sel_oh, acc_oh;
  logic d_multi, d_mem, d_we, d_sf, d_push, d_stk, d_ret, d_rfm, d_imm, d_cond;
  logic [NREG-1:0] d_wr;
  logic [4:0] d_opsel;
  logic [1:0] d_asel, d_wsel;

  // Register one-hots: ACC is the last register, selects past it clamp to it.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      acc_oh[i] = (i == NREG - 1);
      sel_oh[i] = (i == NREG - 1) ? (int'(rd) >= NREG - 1) : (int'(rd) == i);
    end
  end

  // Opcode decode of the latched instruction; unknown opcodes fall through as NOP.
  always_comb begin
    d_multi = 1'b0; d_mem = 1'b0; d_we = 1'b0; d_sf = 1'b0; d_push = 1'b0;
    d_stk = 1'b0; d_ret = 1'b0; d_rfm = 1'b0; d_imm = 1'b0; d_cond = 1'b0;
    d_wr = '0; d_opsel = 5'd0; d_asel = 2'd0; d_wsel = 2'd0;
    case (opc)
      OP_ADDRR:  begin d_opsel = ALU_ADD; d_wr = acc_oh; d_sf = 1'b1; end
      OP_ADDRI:  begin d_opsel = ALU_ADD; d_wr = acc_oh; d_sf = 1'b1; d_imm = 1'b1; end
      OP_SUBRR:  begin d_opsel = ALU_SUB; d_wr = acc_oh; d_sf = 1'b1; end
      OP_SUBRI:  begin d_opsel = ALU_SUB; d_wr = acc_oh; d_sf = 1'b1; d_imm = 1'b1; end
      OP_ANDRR:  begin d_opsel = ALU_AND; d_wr = acc_oh; d_sf = 1'b1; end
      OP_ORRR:   begin d_opsel = ALU_OR;  d_wr = acc_oh; d_sf = 1'b1; end
      OP_XORRR:  begin d_opsel = ALU_XOR; d_wr = acc_oh; d_sf = 1'b1; end
      OP_SHL:    begin d_opsel = ALU_SHL; d_wr = acc_oh; d_sf = 1'b1; end
      OP_SHR:    begin d_opsel = ALU_SHR; d_wr = acc_oh; d_sf = 1'b1; end
      OP_MULRR:  begin d_opsel = ALU_MUL; d_wr = acc_oh; d_sf = 1'b1; d_multi = 1'b1; end
      OP_DIVRR:  begin d_opsel = ALU_DIV; d_wr = acc_oh; d_sf = 1'b1; d_multi = 1'b1; end
      OP_MODRR:  begin d_opsel = ALU_MOD; d_wr = acc_oh; d_sf = 1'b1; d_multi = 1'b1; end
      OP_POWRR:  begin d_opsel = ALU_POW; d_wr = acc_oh; d_sf = 1'b1; d_multi = 1'b1; end
      OP_RADRR:  begin d_opsel = ALU_RAD; d_wr = acc_oh; d_sf = 1'b1; d_multi = 1'b1; end
      OP_CMP:    begin d_opsel = ALU_SUB; d_sf = 1'b1; end
      OP_TST:    begin d_opsel = ALU_AND; d_sf = 1'b1; end
      OP_INC:    begin d_opsel = ALU_INC; d_wr = sel_oh; d_sf = 1'b1; end
      OP_DEC:    begin d_opsel = ALU_DEC; d_wr = sel_oh; d_sf = 1'b1; end
      OP_MOV:    begin d_opsel = ALU_MOV; d_wr = sel_oh; end
      OP_LOAD:   begin d_mem = 1'b1; d_wr = sel_oh; d_rfm = 1'b1; end
      OP_STORE:  begin d_mem = 1'b1; d_we = 1'b1; d_wsel = 2'd1; end
      OP_LOADB:  begin d_mem = 1'b1; d_asel = 2'd1; end
      OP_STOREB: begin d_mem = 1'b1; d_we = 1'b1; d_asel = 2'd1; d_wsel = 2'd1; end
      OP_PUSH:   begin d_mem = 1'b1; d_we = 1'b1; d_asel = 2'd2; d_wsel = 2'd1;
                       d_push = 1'b1; d_stk = 1'b1; end
      OP_POP:    begin d_mem = 1'b1; d_asel = 2'd2; d_wr = sel_oh; d_rfm = 1'b1;
                       d_stk = 1'b1; end
      // JMP pushes the return PC, so it is a stack write like PUSH.
      OP_JMP:    begin d_mem = 1'b1; d_we = 1'b1; d_asel = 2'd2; d_wsel = 2'd2;
                       d_push = 1'b1; d_stk = 1'b1; end
      OP_RET:    begin d_mem = 1'b1; d_asel = 2'd2; d_stk = 1'b1; d_ret = 1'b1; end
      OP_BRE:    d_cond = zf;
      OP_BNE:    d_cond = !zf;
      OP_BLT:    d_cond = nf != of;
      OP_BGT:    d_cond = !zf && (nf == of);
      OP_BLE:    d_cond = zf || (nf != of);
      OP_BGE:    d_cond = nf == of;
      OP_BRC:    d_cond = cf;
      OP_BRO:    d_cond = of;
      OP_BRA:    d_cond = 1'b1;
      default:   ;
    endcase
  end

  // State, latched instruction, branch condition, wait counter and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      instr_q <= '0;
      cond_q  <= 1'b0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      cond_q  <= cond_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d = state_q; instr_d = instr_q; cond_d = cond_q;
    cnt_d = cnt_q; terr_d = terr_q;
    instr_ready = 1'b0; alu_start = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    push = 1'b0; op_stack = 1'b0; wr_reg = '0; save_flags = 1'b0;
    branch = 1'b0; ret = 1'b0; load_pc = 1'b0;
    case (state_q)
      S_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          instr_d = instr[INSTR_W-1 -: 10];
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        cond_d = d_cond;
        cnt_d  = '0;
        if (d_multi) begin
          alu_start = 1'b1;
          state_d   = S_WAIT_ALU;
        end else if (d_mem) begin
          state_d = S_WAIT_MEM;
        end else begin
          state_d = S_COMMIT;
        end
      end
      S_WAIT_ALU, S_WAIT_MEM: begin
        mem_req = (state_q == S_WAIT_MEM);
        mem_we  = (state_q == S_WAIT_MEM) && d_we;
        if ((state_q == S_WAIT_ALU) ? alu_done : mem_ack) begin
          state_d = S_COMMIT;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_FETCH;
          terr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_COMMIT: begin
        load_pc    = 1'b1;
        wr_reg     = d_wr;
        save_flags = d_sf;
        push       = d_push;
        op_stack   = d_stk;
        branch     = cond_q;
        ret        = d_ret;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Decode selects are live from EXEC until the return to FETCH.
  assign busy            = (state_q != S_FETCH);
  assign opsel           = busy ? d_opsel : 5'd0;
  assign sel_srcA        = busy ? rd : 2'd0;
  assign sel_srcB        = busy ? (d_imm ? 2'd3 : rs) : 2'd0;
  assign data_addr_sel   = busy ? d_asel : 2'd0;
  assign mem_data_wr_sel = busy ? d_wsel : 2'd0;
  assign reg_from_mem    = busy && d_rfm;
  assign timeout_err     = terr_q;

endmodule
